mil_word_encoder: RTL and testbench
===================================

// Module: mil_word_encoder
// PURPOSE
//  MIL-STD-1553 Manchester-II word transmitter; sits between the word-level push interface and the bus driver.
//  Serialises one 20-bit-time word per accepted input: 3-bit-time sync, 16 data bits MSB first, odd parity.
//  Drives a differential pair plus driver enable. Holds a minimum line-idle guard after each message.
//  A message is a back-to-back word burst.
// PARAMETERS
//  HALF_BIT   50  clk cycles per half bit time (100 MHz clk -> 1 Mbit/s); legal range >= 2
//  GAP_HB     8   guard time after the last word of a message, in half bits, line idle; legal range >= 1
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, synchronous, active-high
//  in_valid   in   1   word available
//  in_ready   out  1   encoder accepts word this cycle (transfer = in_valid & in_ready)
//  in_data    in   16  data word, bit 15 sent first
//  in_cmd     in   1   1: command/status sync (high then low); 0: data sync (low then high)
//  tx_p       out  1   line positive
//  tx_n       out  1   line negative
//  tx_en      out  1   driver enable
//  busy       out  1   high in SEND or GUARD
//  word_done  out  1   one-cycle strobe after final parity half bit of each word
// BEHAVIOUR
//  Reset
//   - Outputs: in_ready=0 during rst, tx_p=tx_n=tx_en=busy=word_done=0, state IDLE, counters 0.
//   - rst mid-word aborts the word; line idles on the next edge, with no partial parity.
//  Word pattern
//   - At transfer, latch a 40-entry half-bit pattern:
//     - hb0..5 sync: cmd = 1,1,1,0,0,0; data = 0,0,0,1,1,1.
//     - hb6..37: Manchester per bit, 1 -> (1,0), 0 -> (0,1).
//     - hb38..39: parity bit P = ~^in_data (odd parity over data+P), Manchester encoded.
//   - tx_p = pattern[hb], tx_n = ~tx_p while tx_en=1. When tx_en=0, tx_p=tx_n=0.
//  Counters
//   - cyc: 0..HALF_BIT-1, wraps.
//   - hb: 0..39, advances when cyc wraps.
//   - gap: 0..GAP_HB-1, counted in half bits.
//  States
//   - IDLE:
//     - in_ready=1.
//     - On transfer -> SEND; tx_en=1 and hb0 on the following edge (latency 1 clk).
//   - SEND:
//     - in_ready=1 only in the last clk of hb39 (cyc=HALF_BIT-1, hb=39).
//     - Transfer there: load the new pattern, hb=0, stay SEND. The new sync follows with no gap and no idle cycle.
//     - No transfer at the end of hb39: -> GUARD, tx_en=0.
//     - word_done pulses the cycle after the last clk of hb39, whether or not the next word follows.
//   - GUARD:
//     - in_ready=0, line idle.
//     - After GAP_HB full half bits -> IDLE.
//  Boundary conditions
//   - in_valid while not ready: ignored; data need not be held stable beyond the transfer cycle.
//   - Data is latched at transfer; later input changes do not affect the word in flight.
//   - in_valid arriving the same cycle GUARD ends: not accepted until IDLE (one cycle later).
//   - Word length is exactly 40*HALF_BIT clk from the first tx_en high to the end of parity.
//   - A back-to-back pair spans 80*HALF_BIT clk.
//   - busy=1 from the edge after the first transfer until GUARD completes.
// TESTING
//  1. HALF_BIT=4: send cmd=1, data=16'h0000.
//     -> tx_p sequence per half bit: 111000 then (0,1)x16 then parity 1 -> (1,0).
//     -> 160 clk of tx_en; word_done once.
//  2. data=16'hFFFF, cmd=0.
//     -> sync 000111, (1,0)x16, parity 1 -> (1,0).
//     -> tx_n == ~tx_p throughout while tx_en.
//  3. Hold in_valid with 3 words: 16'hA5A5 cmd, 16'h0001 data, 16'h8000 data.
//     -> 480 contiguous tx_en clk; in_ready pulses exactly twice inside SEND; 3 word_done strobes.
//     -> Then GAP_HB*4 clk with tx_en=0 and in_ready=0.
//  4. Assert rst at hb20 of a word.
//     -> Next edge: tx_en=tx_p=tx_n=0, busy=0, no word_done.
//     -> Post-reset word is encoded correctly.
//  5. Randomised data/cmd, 200 words with random in_valid gaps.
//     -> Reference decoder recovers every word; parity odd.
//     -> Every inter-message idle gap is >= GAP_HB*HALF_BIT clk.

Source files
------------

// File: rtl/mil_word_encoder_if.sv
// Word-level push interface between a message source and the 1553 word encoder.
// The source (master) offers a 16-bit word plus a sync-type flag; the encoder
// (slave) signals when it accepts the word.
interface mil_word_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_cmd;

  modport master (
    output in_valid,
    output in_data,
    output in_cmd,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_cmd,
    output in_ready
  );
endinterface

// File: rtl/mil_word_encoder.sv
// MIL-STD-1553 Manchester-II word transmitter.
// Each accepted word becomes a 40-half-bit line pattern: 3 bit-time sync,
// 16 data bits MSB first, odd parity. Words offered exactly at the end of the
// previous word are chained with no idle; otherwise the line is held idle for
// a guard time before the next message may start.
module mil_word_encoder #(
  parameter int HALF_BIT = 50,
  parameter int GAP_HB   = 8
) (
  input  logic             clk,
  input  logic             rst,
  mil_word_encoder_if.slave bus,
  output logic             tx_p,
  output logic             tx_n,
  output logic             tx_en,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(HALF_BIT);
  localparam int GW = $clog2(GAP_HB + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(HALF_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_HB - 1);
  localparam logic [5:0]    HB_LAST  = 6'd39;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [5:0]    r_hb;
  logic [GW-1:0] r_gap;
  logic [39:0]   r_pat;
  logic          r_tx_en;
  logic          r_busy;
  logic          r_word_done;

  logic w_cyc_wrap;
  logic w_word_end;
  logic w_ready;
  logic w_xfer;

  // Build the full half-bit line pattern; bit 39 goes on the line first.
  function automatic logic [39:0] f_pattern(input logic cmd, input logic [15:0] data);
    logic [39:0] pat;
    logic        par;
    pat        = '0;
    pat[39:34] = cmd ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 16; i++) begin
      pat[33 - 2*i] = data[15 - i];
      pat[32 - 2*i] = ~data[15 - i];
    end
    par    = ~^data;
    pat[1] = par;
    pat[0] = ~par;
    return pat;
  endfunction

  assign w_cyc_wrap   = (r_cyc == CYC_LAST);
  assign w_word_end   = (r_state == S_SEND) && w_cyc_wrap && (r_hb == HB_LAST);
  // Accept in IDLE, or in the very last clock of a word so the next sync
  // follows the parity half bit with no idle cycle.
  assign w_ready      = !rst && ((r_state == S_IDLE) || w_word_end);
  assign w_xfer       = w_ready && bus.in_valid;
  assign bus.in_ready = w_ready;

  // Line drive: complementary pair while enabled, both low when idle.
  assign tx_p      = r_tx_en & r_pat[39];
  assign tx_n      = r_tx_en & ~r_pat[39];
  assign tx_en     = r_tx_en;
  assign busy      = r_busy;
  assign word_done = r_word_done;

  // Control FSM: half-bit timing, word sequencing and post-message guard.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cyc       <= '0;
      r_hb        <= '0;
      r_gap       <= '0;
      r_tx_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_word_done <= 1'b0;
    end else begin
      r_word_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state <= S_SEND;
            r_tx_en <= 1'b1;
            r_busy  <= 1'b1;
            r_cyc   <= '0;
            r_hb    <= '0;
          end
        end
        S_SEND: begin
          if (w_cyc_wrap) begin
            r_cyc <= '0;
            if (r_hb == HB_LAST) begin
              r_word_done <= 1'b1;
              r_hb        <= '0;
              if (!w_xfer) begin
                r_state <= S_GUARD;
                r_tx_en <= 1'b0;
                r_gap   <= '0;
              end
            end else begin
              r_hb <= r_hb + 6'd1;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        S_GUARD: begin
          if (w_cyc_wrap) begin
            r_cyc <= '0;
            if (r_gap == GAP_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_gap   <= '0;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pattern shifter: load on acceptance, advance one half bit per wrap while sending.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_pat <= f_pattern(bus.in_cmd, bus.in_data);
    end else if ((r_state == S_SEND) && w_cyc_wrap) begin
      r_pat <= {r_pat[38:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_mil_word_encoder.sv
// Bench for mil_word_encoder: timeline model of the line plus a word decoder.
module tb_mil_word_encoder;
  localparam int HB   = 4;
  localparam int GAP  = 8;
  localparam int WLEN = 40 * HB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_p, tx_n, tx_en, busy, word_done;

  mil_word_encoder_if bus ();

  mil_word_encoder #(.HALF_BIT(HB), .GAP_HB(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tx_p      (tx_p),
    .tx_n      (tx_n),
    .tx_en     (tx_en),
    .busy      (busy),
    .word_done (word_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always @(posedge clk) n++;

  // Model state: a word occupies cycles ws..ws+WLEN-1 after acceptance.
  int          ws    = -100000;
  int          gend  = -1;
  int          wdcyc = -1;
  logic [39:0] m_pat = '0;
  logic [39:0] cap   = '0;
  logic [39:0] last_cap = '0;
  logic [16:0] sent_q[$];
  int          fall_at = -1;
  logic        prev_en = 1'b0;
  int          dec_cnt = 0;

  // Per-test statistics
  int en_cnt = 0, wd_cnt = 0, xfer_send = 0, run = 0, max_run = 0, guard_cnt = 0, comp_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, n, act, exp);
    end
  endtask

  // Line pattern straight from the word rules, built as a half-bit stream.
  function automatic logic [39:0] model_word(input logic cmd, input logic [15:0] d);
    logic [39:0] w;
    logic [5:0]  sync;
    logic        par;
    w    = '0;
    sync = cmd ? 6'b111000 : 6'b000111;
    for (int i = 5; i >= 0; i--) w = {w[38:0], sync[i]};
    par = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      w   = {w[38:0], d[i]};
      w   = {w[38:0], ~d[i]};
      par = par ^ d[i];
    end
    w = {w[38:0], par};
    w = {w[38:0], ~par};
    return w;
  endfunction

  // Reference decoder: recovers {cmd,data} from 40 sampled half bits.
  function automatic void decode(input logic [39:0] w, output logic ok, output logic [16:0] word);
    logic        c;
    logic [15:0] d;
    logic [1:0]  pr;
    ok = 1'b1;
    c  = 1'b0;
    d  = '0;
    if (w[39:34] == 6'b111000) c = 1'b1;
    else if (w[39:34] != 6'b000111) ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pr = w[33 - 2*i -: 2];
      if (pr[1] == pr[0]) ok = 1'b0;
      d[15 - i] = pr[1];
    end
    if (w[1] == w[0]) ok = 1'b0;
    if ((^{d, w[1]}) !== 1'b1) ok = 1'b0;
    word = {c, d};
  endfunction

  // Compare process: expected outputs from the timeline model every cycle.
  always @(negedge clk) begin
    if (n >= 1) begin
      int   k;
      logic in_word, e_rdy, e_p, e_busy, e_wd;
      logic dok;
      logic [16:0] dword;
      k       = n - ws;
      in_word = (k >= 0) && (k < WLEN);
      e_p     = in_word ? m_pat[39 - k / HB] : 1'b0;
      e_busy  = in_word || (n <= gend);
      e_wd    = (n == wdcyc);
      e_rdy   = !rst && ((in_word && k == WLEN - 1) || (!in_word && n > gend));
      check("line", {58'd0, bus.in_ready, tx_en, tx_p, tx_n, busy, word_done},
            {58'd0, e_rdy, in_word, e_p, in_word & ~e_p, e_busy, e_wd});

      if (tx_en) begin en_cnt++; run++; end else run = 0;
      if (run > max_run) max_run = run;
      if (word_done) wd_cnt++;
      if (busy && !tx_en) guard_cnt++;
      if (tx_en && (tx_n !== ~tx_p)) comp_err++;
      if (bus.in_ready && bus.in_valid && tx_en) xfer_send++;

      if (!prev_en && tx_en && fall_at >= 0)
        check("idle_gap_ok", {63'd0, (n - fall_at) >= GAP * HB}, 64'd1);
      if (prev_en && !tx_en) fall_at = n;
      prev_en = tx_en;

      if (in_word && (k % HB == 0)) cap = {cap[38:0], tx_p};
      if (in_word && k == WLEN - 1) begin
        last_cap = cap;
        decode(cap, dok, dword);
        dec_cnt++;
        check("decode_ok", {63'd0, dok}, 64'd1);
        if (sent_q.size() == 0) check("decode_unexpected", {47'd0, dword}, 64'h1_0000_0000);
        else check("decode_word", {47'd0, dword}, {47'd0, sent_q.pop_front()});
      end

      if (rst) begin
        ws      = -100000;
        gend    = -1;
        wdcyc   = -1;
        fall_at = -1;
        prev_en = 1'b0;
        sent_q.delete();
      end else begin
        if (in_word && k == WLEN - 1) wdcyc = n + 1;
        if (e_rdy && bus.in_valid) begin
          ws    = n + 1;
          m_pat = model_word(bus.in_cmd, bus.in_data);
        end else if (in_word && k == WLEN - 1) begin
          gend = n + GAP * HB;
        end
      end
    end
  end

  task automatic clear_stats();
    en_cnt = 0; wd_cnt = 0; xfer_send = 0; max_run = 0; guard_cnt = 0; comp_err = 0;
  endtask

  task automatic send(input logic cmd, input logic [15:0] data, input bit hold);
    bit got;
    got = 0;
    bus.in_valid = 1'b1;
    bus.in_cmd   = cmd;
    bus.in_data  = data;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted");
    end
    @(posedge clk);
    #1;
    if (got) sent_q.push_back({cmd, data});
    bus.in_data = ~data;
    bus.in_cmd  = ~cmd;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!busy && bus.in_ready) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] exp_w;
    int          dec0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_cmd   = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {58'd0, bus.in_ready, tx_en, tx_p, tx_n, busy, word_done}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Model pinned to hand-derived patterns
    exp_w = model_word(1'b1, 16'h0000);
    check("model_cmd_0000", {24'd0, exp_w}, {24'd0, 40'hE1_5555_5556});
    exp_w = model_word(1'b0, 16'hFFFF);
    check("model_data_FFFF", {24'd0, exp_w}, {24'd0, 40'h1E_AAAA_AAAA});

    // 1: command word 0x0000
    clear_stats();
    send(1'b1, 16'h0000, 0);
    wait_idle();
    check("t1_line", {24'd0, last_cap}, {24'd0, 40'hE1_5555_5556});
    check("t1_en_cycles", en_cnt, WLEN);
    check("t1_word_done", wd_cnt, 1);

    // 2: data word 0xFFFF
    clear_stats();
    send(1'b0, 16'hFFFF, 0);
    wait_idle();
    check("t2_line", {24'd0, last_cap}, {24'd0, 40'h1E_AAAA_AAAA});
    check("t2_en_cycles", en_cnt, WLEN);
    check("t2_complement", comp_err, 0);

    // 3: three-word message with in_valid held
    clear_stats();
    send(1'b1, 16'hA5A5, 1);
    send(1'b0, 16'h0001, 1);
    send(1'b0, 16'h8000, 0);
    wait_idle();
    check("t3_contig_en", max_run, 3 * WLEN);
    check("t3_en_cycles", en_cnt, 3 * WLEN);
    check("t3_send_accepts", xfer_send, 2);
    check("t3_word_done", wd_cnt, 3);
    check("t3_guard_cycles", guard_cnt, GAP * HB);

    // 4: reset at half bit 20
    send(1'b1, 16'h3C5A, 0);
    repeat (20 * HB) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4_after_rst", {59'd0, tx_en, tx_p, tx_n, busy, word_done}, 64'd0);
    @(posedge clk);
    #1;
    send(1'b0, 16'h1234, 0);
    wait_idle();
    check("t4_post_word", {24'd0, last_cap}, {24'd0, 40'h1D_5965_6995});

    // 5: 200 random words with random gaps
    dec0 = dec_cnt;
    for (int i = 0; i < 200; i++) begin
      bit hold;
      hold = (i != 199) && ($urandom_range(0, 3) != 0);
      send(1'($urandom_range(0, 1)), 16'($urandom), hold);
      if (!hold) begin
        bus.in_data = 16'($urandom);
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    check("t5_decoded", dec_cnt - dec0, 200);
    check("t5_queue_empty", sent_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
